// File: rtl/ma_bus_if.sv
// Request, AHB3-Lite and result signals of the memory-access bus controller.
// The master modport is the controller's view; slave is the environment's view.
interface ma_bus_if #(
  parameter int ADDR_W = 32
);
  logic              s_flush_i;
  logic              s_approve_i;
  logic [ADDR_W-1:0] s_addr_i;
  logic [31:0]       s_wdata_i;
  logic [3:0]        s_f_i;
  logic              s_idempotent_i;
  logic [ADDR_W-1:0] s_haddr_o;
  logic [1:0]        s_htrans_o;
  logic              s_hwrite_o;
  logic [2:0]        s_hsize_o;
  logic [3:0]        s_hprot_o;
  logic [31:0]       s_hwdata_o;
  logic [31:0]       s_hrdata_i;
  logic              s_hready_i;
  logic              s_hresp_i;
  logic              s_busy_o;
  logic              s_res_valid_o;
  logic              s_res_err_o;
  logic [31:0]       s_res_data_o;

  modport master (
    input  s_flush_i, s_approve_i, s_addr_i, s_wdata_i, s_f_i, s_idempotent_i,
    input  s_hrdata_i, s_hready_i, s_hresp_i,
    output s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hprot_o, s_hwdata_o,
    output s_busy_o, s_res_valid_o, s_res_err_o, s_res_data_o
  );

  modport slave (
    output s_flush_i, s_approve_i, s_addr_i, s_wdata_i, s_f_i, s_idempotent_i,
    output s_hrdata_i, s_hready_i, s_hresp_i,
    input  s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hprot_o, s_hwdata_o,
    input  s_busy_o, s_res_valid_o, s_res_err_o, s_res_data_o
  );
endinterface

// File: rtl/ma_bus_ctrl.sv
// Memory-access stage AHB3-Lite data-bus controller: issues approved load/store
// requests, holds stalled address phases, aligns load data and reports results.
module ma_bus_ctrl #(
  parameter int ADDR_W             = 32,
  parameter bit ERR_ON_IDLE_CANCEL = 1'b1
) (
  input logic      s_clk_i,
  input logic      s_resetn_i,
  ma_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, AWAIT, DATA, ERR} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_p0;
  logic              write_p0, uns_p0, idem_p0, pend_p0, cancel_p0;
  logic [1:0]        size_p0;
  logic [31:0]       wdata_p0;

  logic              write_p1, uns_p1, cancel_p1;
  logic [1:0]        size_p1, off_p1;
  logic [31:0]       wdata_p1;

  logic              vld_p2, err_p2;
  logic [31:0]       data_p2;

  logic              drive, use_hold, accept, capture, done, done_err, pend_nxt;
  logic              done_cancel;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write, a_uns, a_idem;
  logic [1:0]        a_size;
  logic [31:0]       a_wdata;

  function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Address-phase source: the held request while stalled, else the live EX request.
  always_comb begin
    if (use_hold) begin
      a_addr  = addr_p0;
      a_write = write_p0;
      a_uns   = uns_p0;
      a_idem  = idem_p0;
      a_size  = size_p0;
      a_wdata = wdata_p0;
    end else begin
      a_addr  = bus.s_addr_i;
      a_write = bus.s_f_i[3];
      a_uns   = bus.s_f_i[2];
      a_idem  = bus.s_idempotent_i;
      a_size  = bus.s_f_i[1:0];
      a_wdata = bus.s_wdata_i;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    drive     = 1'b0;
    use_hold  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_approve_i) begin
          drive = 1'b1;
          if (bus.s_hready_i) begin
            accept    = 1'b1;
            state_nxt = DATA;
          end else begin
            capture   = 1'b1;
            state_nxt = AWAIT;
          end
        end
      end
      AWAIT: begin
        drive    = 1'b1;
        use_hold = 1'b1;
        if (bus.s_hready_i) begin
          accept    = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.s_hready_i) begin
          done     = 1'b1;
          done_err = bus.s_hresp_i;
          if (pend_p0) begin
            drive     = 1'b1;
            use_hold  = 1'b1;
            accept    = 1'b1;
            state_nxt = DATA;
          end else if (bus.s_approve_i) begin
            drive     = 1'b1;
            accept    = 1'b1;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else if (bus.s_hresp_i) begin
          // First error cycle: nothing is accepted; a pending address is dropped.
          drive     = !ERR_ON_IDLE_CANCEL && (pend_p0 || bus.s_approve_i);
          use_hold  = pend_p0;
          state_nxt = ERR;
        end else if (pend_p0) begin
          drive    = 1'b1;
          use_hold = 1'b1;
        end else if (bus.s_approve_i) begin
          drive   = 1'b1;
          capture = 1'b1;
        end
      end
      ERR: begin
        if (bus.s_hready_i) begin
          done      = 1'b1;
          done_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_htrans_o = drive ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.s_haddr_o  = drive ? a_addr : '0;
    bus.s_hwrite_o = drive && a_write;
    bus.s_hsize_o  = drive ? {1'b0, a_size} : 3'b000;
    bus.s_hprot_o  = drive ? {3'b001, a_idem} : 4'b0011;
    bus.s_hwdata_o = rep_wdata(size_p1, wdata_p1);
    bus.s_busy_o   = (state == AWAIT) || (state == ERR) ||
                     ((state == DATA) && !bus.s_hready_i);
    bus.s_res_valid_o = vld_p2;
    bus.s_res_err_o   = err_p2;
    bus.s_res_data_o  = data_p2;
  end

  assign pend_nxt    = (state == DATA) && !bus.s_hready_i && !bus.s_hresp_i && (capture || pend_p0);
  assign done_cancel = cancel_p1 || bus.s_flush_i;

  // p0: address phase held while HREADY is low
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      addr_p0   <= '0;
      write_p0  <= 1'b0;
      uns_p0    <= 1'b0;
      idem_p0   <= 1'b0;
      size_p0   <= 2'b00;
      wdata_p0  <= '0;
      pend_p0   <= 1'b0;
      cancel_p0 <= 1'b0;
    end else begin
      pend_p0 <= pend_nxt;
      if (capture) begin
        addr_p0   <= a_addr;
        write_p0  <= a_write;
        uns_p0    <= a_uns;
        idem_p0   <= a_idem;
        size_p0   <= a_size;
        wdata_p0  <= a_wdata;
        cancel_p0 <= bus.s_flush_i;
      end else begin
        cancel_p0 <= (cancel_p0 || bus.s_flush_i) && !accept &&
                     ((state_nxt == AWAIT) || pend_nxt);
      end
    end
  end

  // p1: data phase of the accepted transfer
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      write_p1  <= 1'b0;
      uns_p1    <= 1'b0;
      size_p1   <= 2'b00;
      off_p1    <= 2'b00;
      wdata_p1  <= '0;
      cancel_p1 <= 1'b0;
    end else if (accept) begin
      write_p1  <= a_write;
      uns_p1    <= a_uns;
      size_p1   <= a_size;
      off_p1    <= a_addr[1:0];
      wdata_p1  <= a_wdata;
      cancel_p1 <= (use_hold && cancel_p0) || bus.s_flush_i;
    end else if (done) begin
      cancel_p1 <= 1'b0;
    end else if ((state == DATA) || (state == ERR)) begin
      cancel_p1 <= cancel_p1 || bus.s_flush_i;
    end
  end

  // p2: registered result report
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      vld_p2  <= 1'b0;
      err_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= done && !done_err && !done_cancel;
      err_p2  <= done && done_err && !done_cancel;
      data_p2 <= (done && !done_err && !done_cancel && !write_p1) ?
                 align_load(bus.s_hrdata_i, off_p1, size_p1, uns_p1) : '0;
    end
  end

endmodule

// File: tb/tb_ma_bus_ctrl.sv
// Bench for ma_bus_ctrl: vector table of zero-wait transfers plus hand-written
// wait-state, flush, back-to-back, error and reset sequences, with a result scoreboard.
module tb_ma_bus_ctrl;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        idem;
    logic [31:0] hrdata;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb[$];
  vec_t vecs[9];

  ma_bus_if #(.ADDR_W(32)) bus ();

  ma_bus_ctrl #(.ADDR_W(32), .ERR_ON_IDLE_CANCEL(1'b1)) dut (
    .s_clk_i   (clk),
    .s_resetn_i(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit ap, input logic [31:0] a, input logic [3:0] f,
                     input logic [31:0] wd, input bit idem, input bit rdy,
                     input bit resp, input logic [31:0] rd, input bit fl);
    @(negedge clk);
    bus.s_approve_i    = ap;
    bus.s_addr_i       = a;
    bus.s_f_i          = f;
    bus.s_wdata_i      = wd;
    bus.s_idempotent_i = idem;
    bus.s_hready_i     = rdy;
    bus.s_hresp_i      = resp;
    bus.s_hrdata_i     = rd;
    bus.s_flush_i      = fl;
    #1;
  endtask

  task automatic idle(input bit rdy);
    drv(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.s_res_valid_o || bus.s_res_err_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got valid=%0b err=%0b data=%h want no result at %0t",
                 bus.s_res_valid_o, bus.s_res_err_o, bus.s_res_data_o, $time);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_err",   {31'h0, bus.s_res_err_o},   {31'h0, e.err});
        chk("sb_valid", {31'h0, bus.s_res_valid_o}, {31'h0, !e.err});
        chk("sb_data",  bus.s_res_data_o, e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0010, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 3'b010, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{4'b0000, 32'h103, 32'h0,        1'b1, 32'h80FF0000, 3'b000, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{4'b0100, 32'h103, 32'h0,        1'b1, 32'h80FF0000, 3'b000, 32'h0,        32'h00000080};
    vecs[3] = '{4'b0001, 32'h202, 32'h0,        1'b1, 32'h80011234, 3'b001, 32'h0,        32'hFFFF8001};
    vecs[4] = '{4'b0101, 32'h202, 32'h0,        1'b1, 32'h80011234, 3'b001, 32'h0,        32'h00008001};
    vecs[5] = '{4'b0000, 32'h101, 32'h0,        1'b1, 32'h00007F00, 3'b000, 32'h0,        32'h0000007F};
    vecs[6] = '{4'b1001, 32'h202, 32'h1234ABCD, 1'b1, 32'hFFFFFFFF, 3'b001, 32'hABCDABCD, 32'h0};
    vecs[7] = '{4'b1000, 32'h301, 32'hAABBCC5A, 1'b1, 32'hFFFFFFFF, 3'b000, 32'h5A5A5A5A, 32'h0};
    vecs[8] = '{4'b1010, 32'h400, 32'hCAFEF00D, 1'b0, 32'hFFFFFFFF, 3'b010, 32'hCAFEF00D, 32'h0};

    rst_n = 1'b0;
    idle(1'b1);
    idle(1'b1);
    chk("rst_htrans", {30'h0, bus.s_htrans_o}, 32'h0);
    chk("rst_haddr",  bus.s_haddr_o, 32'h0);
    chk("rst_hwrite", {31'h0, bus.s_hwrite_o}, 32'h0);
    chk("rst_hsize",  {29'h0, bus.s_hsize_o}, 32'h0);
    chk("rst_hprot",  {28'h0, bus.s_hprot_o}, 32'h3);
    chk("rst_hwdata", bus.s_hwdata_o, 32'h0);
    chk("rst_busy",   {31'h0, bus.s_busy_o}, 32'h0);
    chk("rst_valid",  {31'h0, bus.s_res_valid_o}, 32'h0);
    chk("rst_err",    {31'h0, bus.s_res_err_o}, 32'h0);
    chk("rst_data",   bus.s_res_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait-state transfers from the vector table
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, vecs[i].addr, vecs[i].f, vecs[i].wdata, vecs[i].idem, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("v_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
      chk("v_haddr",  bus.s_haddr_o, vecs[i].addr);
      chk("v_hsize",  {29'h0, bus.s_hsize_o}, {29'h0, vecs[i].exp_hsize});
      chk("v_hwrite", {31'h0, bus.s_hwrite_o}, {31'h0, vecs[i].f[3]});
      chk("v_hprot",  {28'h0, bus.s_hprot_o}, {28'h0, 3'b001, vecs[i].idem});
      sb.push_back('{1'b0, vecs[i].exp_data});
      drv(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, vecs[i].hrdata, 1'b0);
      chk("v_dp_htrans", {30'h0, bus.s_htrans_o}, 32'h0);
      chk("v_dp_busy",   {31'h0, bus.s_busy_o}, 32'h0);
      if (vecs[i].f[3]) chk("v_hwdata", bus.s_hwdata_o, vecs[i].exp_hwdata);
      idle(1'b1);
      chk("v_lat_valid", {31'h0, bus.s_res_valid_o}, 32'h1);
    end

    // Address wait states with a flush: address held, report suppressed
    drv(1'b1, 32'h500, 4'b0010, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ws0_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("ws0_haddr",  bus.s_haddr_o, 32'h500);
    drv(1'b0, 32'hFFF0, 4'b1001, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("ws1_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("ws1_haddr",  bus.s_haddr_o, 32'h500);
    chk("ws1_busy",   {31'h0, bus.s_busy_o}, 32'h1);
    drv(1'b0, 32'hFFF0, 4'b1001, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ws2_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("ws2_haddr",  bus.s_haddr_o, 32'h500);
    chk("ws2_hsize",  {29'h0, bus.s_hsize_o}, 32'h2);
    drv(1'b0, 32'hFFF0, 4'b1001, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("ws3_haddr",  bus.s_haddr_o, 32'h500);
    idle(1'b1);
    idle(1'b1);
    chk("ws_no_valid", {31'h0, bus.s_res_valid_o}, 32'h0);

    // Back-to-back load then store, no stall
    drv(1'b1, 32'h600, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    sb.push_back('{1'b0, 32'h0A0B0C0D});
    chk("b2b_busy0", {31'h0, bus.s_busy_o}, 32'h0);
    drv(1'b1, 32'h604, 4'b1010, 32'h11223344, 1'b1, 1'b1, 1'b0, 32'h0A0B0C0D, 1'b0);
    sb.push_back('{1'b0, 32'h0});
    chk("b2b_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("b2b_haddr",  bus.s_haddr_o, 32'h604);
    chk("b2b_busy1",  {31'h0, bus.s_busy_o}, 32'h0);
    idle(1'b1);
    chk("b2b_hwdata", bus.s_hwdata_o, 32'h11223344);
    chk("b2b_valid1", {31'h0, bus.s_res_valid_o}, 32'h1);
    chk("b2b_busy2",  {31'h0, bus.s_busy_o}, 32'h0);
    idle(1'b1);
    chk("b2b_valid2", {31'h0, bus.s_res_valid_o}, 32'h1);

    // Two-cycle error response; the approve in the first error cycle is refused
    drv(1'b1, 32'h700, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    drv(1'b1, 32'h704, 4'b0010, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("err1_htrans", {30'h0, bus.s_htrans_o}, 32'h0);
    chk("err1_busy",   {31'h0, bus.s_busy_o}, 32'h1);
    drv(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    sb.push_back('{1'b1, 32'h0});
    chk("err2_htrans", {30'h0, bus.s_htrans_o}, 32'h0);
    chk("err2_busy",   {31'h0, bus.s_busy_o}, 32'h1);
    idle(1'b1);
    chk("err_pulse",  {31'h0, bus.s_res_err_o}, 32'h1);
    chk("err_valid0", {31'h0, bus.s_res_valid_o}, 32'h0);
    chk("err_busy3",  {31'h0, bus.s_busy_o}, 32'h0);
    idle(1'b1);
    chk("err_once", {31'h0, bus.s_res_err_o}, 32'h0);

    // New address while the previous data phase is stalled
    drv(1'b1, 32'h800, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    sb.push_back('{1'b0, 32'h13572468});
    drv(1'b1, 32'h804, 4'b1010, 32'h99887766, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    sb.push_back('{1'b0, 32'h0});
    chk("pd1_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("pd1_haddr",  bus.s_haddr_o, 32'h804);
    drv(1'b0, 32'hBAD0, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pd2_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    chk("pd2_haddr",  bus.s_haddr_o, 32'h804);
    chk("pd2_hwrite", {31'h0, bus.s_hwrite_o}, 32'h1);
    drv(1'b0, 32'hBAD0, 4'b0000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h13572468, 1'b0);
    chk("pd3_haddr",  bus.s_haddr_o, 32'h804);
    idle(1'b1);
    chk("pd4_hwdata", bus.s_hwdata_o, 32'h99887766);
    idle(1'b1);

    // Flush in the acceptance cycle cancels that report only
    drv(1'b1, 32'hA00, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("fa_no_valid", {31'h0, bus.s_res_valid_o}, 32'h0);

    // Reset in the middle of a stalled data phase
    drv(1'b1, 32'h900, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("mr_busy_pre", {31'h0, bus.s_busy_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy",   {31'h0, bus.s_busy_o}, 32'h0);
    chk("mr_htrans", {30'h0, bus.s_htrans_o}, 32'h0);
    idle(1'b1);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    chk("mr_no_valid", {31'h0, bus.s_res_valid_o}, 32'h0);

    // FSM still usable after everything above
    drv(1'b1, 32'hB00, 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    sb.push_back('{1'b0, 32'h5A5AA5A5});
    chk("post_htrans", {30'h0, bus.s_htrans_o}, 32'h2);
    drv(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h5A5AA5A5, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("sb_drain", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
